// File: rtl/snapshot_pkg.sv
// Shared definitions for the BRAM snapshot writer: FSM state encoding and
// the effective-length rule (zero or oversize length selects the full depth).
package snapshot_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } snap_state_t;

  // Zero or a length beyond the buffer depth means "capture the whole buffer".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned aw);
    int unsigned depth;
    depth = 32'd1 << aw;
    if (len == 0 || len > depth) return depth;
    return len;
  endfunction

endpackage

// File: rtl/bram_snapshot_writer.sv
// Captures a bounded snapshot of the correlator stream into BRAM port B.
// Arm/length control with busy/done status; single clock domain (axi_clock).
// Optional macro SNAPSHOT_TRIGGER_EN adds a trig input and a WAIT_TRIG state
// that holds off the capture until the first cycle with trig=1.
module bram_snapshot_writer
  import snapshot_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  axi_clock,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  arm,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef SNAPSHOT_TRIGGER_EN
  input  logic                  trig,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_en,
  output logic                  bram_we
);

  localparam int CW = ADDR_WIDTH + 1;

  snap_state_t           r_state;
  snap_state_t           w_state_nxt;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic [DATA_WIDTH-1:0] r_bram_din;
  logic                  r_bram_we;
  logic                  w_write;
  logic                  w_arm_ok;
  logic [ADDR_WIDTH:0]   w_count_inc;
  logic [ADDR_WIDTH:0]   w_len_eff;

  assign w_count_inc = r_count + CW'(1);
  assign w_len_eff   = CW'(eff_len(32'(length), ADDR_WIDTH));

  // State register.
  always_ff @(posedge axi_clock) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: decides when to accept arm and when a sample is written.
  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_arm_ok    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (arm) begin
          w_arm_ok = 1'b1;
`ifdef SNAPSHOT_TRIGGER_EN
          w_state_nxt = WAIT_TRIG;
`else
          w_state_nxt = CAPTURE;
`endif
        end
      end
      WAIT_TRIG: begin
`ifdef SNAPSHOT_TRIGGER_EN
        // The trigger cycle's own sample is the first word of the snapshot.
        if (trig) begin
          w_state_nxt = CAPTURE;
          if (din_valid) begin
            w_write = 1'b1;
            if (w_count_inc == r_len) w_state_nxt = DONE;
          end
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      CAPTURE: begin
        if (din_valid) begin
          w_write = 1'b1;
          if (w_count_inc == r_len) w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter, latched length and registered BRAM port-B outputs.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      r_count     <= '0;
      r_len       <= '0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_bram_we   <= 1'b0;
    end else begin
      r_bram_we <= w_write;
      if (w_arm_ok) begin
        r_count <= '0;
        r_len   <= w_len_eff;
      end else if (w_write) begin
        r_count     <= w_count_inc;
        r_bram_addr <= r_count[ADDR_WIDTH-1:0];
        r_bram_din  <= din;
      end
    end
  end

  assign busy      = (r_state == CAPTURE) || (r_state == WAIT_TRIG);
  assign done      = (r_state == DONE);
  assign wr_count  = r_count;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;
  assign bram_en   = r_bram_we;
  assign bram_we   = r_bram_we;

endmodule
